mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Memory-stage controller between the pipeline's address/store-data outputs and the data memory, immediately upstream of the load-extension stage. It accepts one load or store per request, checks alignment, and drives a req/ack handshake to a variable-latency data memory with store byte-lane steering. For loads it captures the raw memory word and, alongside it, the byte offset, size and sign controls that the load-extension stage consumes.

## Interface
- WAIT_MAX, 15: cycles in ACCESS without MemAck before timeout abort (1..255).
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Req  in  1  access request, sampled only in IDLE.
- We  in  1  1 = store, 0 = load.
- Addr  in  32  byte address.
- Size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- Sign  in  1  1 = unsigned, 0 = signed (load only).
- WData  in  32  store data, right-aligned.
- Busy  out  1  stall to pipeline; high while in ACCESS.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  one-cycle pulse: misaligned/illegal request or timeout.
- MemReq  out  1  memory request.
- MemWe  out  1  memory write enable.
- MemAddr  out  32  word address ({Addr[31:2],2'b00}).
- MemBe  out  4  byte-lane enables.
- MemWData  out  32  lane-steered store data.
- MemRData  in  32  memory read data, valid with MemAck.
- MemAck  in  1  memory completion.
- LD  out  32  raw captured load word.
- LOff  out  2  Addr[1:0] of the captured load.
- LSize  out  2  Size of the captured load.
- LSign  out  1  Sign of the captured load.

## Operation
- FSM states: IDLE, ACCESS.
- IDLE with Req=1 and a legal request: latch We/Addr/Size/Sign and steered data/enables, then go to ACCESS.
- Illegal requests: Size=11, halfword with Addr[0]=1, or word with Addr[1:0]≠00. These pulse Err, stay in IDLE, and generate no memory traffic.
- ACCESS: MemReq=1 and memory outputs held stable until MemAck=1, then return to IDLE.
- MemAck while MemReq=0 is ignored.
- Lane k is bits [8k+7:8k] (little-endian).
- Byte access: MemBe=1<<Addr[1:0]; MemWData = WData[7:0] replicated ×4.
- Halfword access: MemBe=0011 at offset 0, 1100 at offset 2; MemWData = WData[15:0] replicated ×2.
- Word access: MemBe=1111; MemWData=WData.
- Loads drive the same MemBe pattern and MemWData=0.
- Load completion: LD<=MemRData; LOff/LSize/LSign <= the latched values. These outputs hold until the next successful load; stores and errors leave them unchanged.
- Timeout: an 8-bit wait counter clears on entering ACCESS and increments each ACCESS cycle without ack. When it reaches WAIT_MAX with no ack, the block aborts to IDLE and pulses Err. Done is not asserted and LD is unchanged.

## Timing
- Reset (asynchronous, immediate) puts the FSM in IDLE with all outputs 0, including LD/LOff/LSize/LSign.
- Reset mid-access drops MemReq at once and produces no Done.
- Req accepted at edge N: from N+1, MemReq=1, Busy=1 and memory outputs are valid.
- MemAck sampled high at edge M: from M+1, MemReq=0, Busy=0, Done=1 for one cycle, and LD is valid.
- Minimum latency is Req to Done in 2 cycles.
- Err for an illegal request appears the cycle after Req is sampled.
- A Req present in the Done cycle is accepted, giving back-to-back accesses with one idle-state cycle between MemReq bursts.
- Inputs may change after acceptance; the pipeline stalls on Busy.
- MemAck in the same cycle the counter reaches WAIT_MAX is treated as ack (completion wins over timeout).

## Test plan
- Load byte: Addr=0x103, Size=00, Sign=1, MemRData=0x0000FFFF, ack after 2 cycles. Expect MemAddr=0x100, MemBe=1000, Done pulse, LD=0x0000FFFF, LOff=11, LSize=00, LSign=1.
- Store halfword: Addr=0x22, WData=0x1234ABCD, ack at first cycle. Expect MemBe=1100, MemWData=0xABCDABCD, MemWe=1, Done 2 cycles after Req, LD unchanged.
- Misaligned word at Addr=0x06. Expect Err pulse, MemReq never asserts, Busy stays 0.
- No ack with WAIT_MAX=15. Expect MemReq high exactly 15 cycles, then Err pulse, no Done.
- Reset_n low while MemReq=1. Expect MemReq/Busy/LD all 0 immediately; a later load completes normally.
- Back-to-back: second load Req held high during the first Done cycle. Expect the second load accepted, MemReq reasserted on the next cycle, and two Done pulses.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller: alignment check, req/ack handshake with
// timeout, store lane steering and capture of raw load data for the extender.
module mem_access_ctrl #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Req,
    input  logic        We,
    input  logic [31:0] Addr,
    input  logic [1:0]  Size,
    input  logic        Sign,
    input  logic [31:0] WData,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemBe,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    input  logic        MemAck,
    output logic [31:0] LD,
    output logic [1:0]  LOff,
    output logic [1:0]  LSize,
    output logic        LSign
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Abort fires on the last waiting cycle so MemReq is high exactly WAIT_MAX cycles.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    function automatic logic is_legal(input logic [1:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            2'b00:   ok = 1'b1;
            2'b01:   ok = (off[0] == 1'b0);
            2'b10:   ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] steer_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{wdata[7:0]}};
            2'b01:   d = {2{wdata[15:0]}};
            2'b10:   d = wdata;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] ld_q, ld_d;
    logic [1:0]  loff_q, loff_d;
    logic [1:0]  lsize_q, lsize_d;
    logic        lsign_q, lsign_d;

    logic        req_legal_s;
    logic [3:0]  req_be_s;
    logic [31:0] req_wdata_s;

    // Decode the incoming request into legality, lane enables and steered data.
    always_comb begin
        req_legal_s = is_legal(Size, Addr[1:0]);
        req_be_s    = lane_be(Size, Addr[1:0]);
        req_wdata_s = We ? steer_data(Size, WData) : 32'h0000_0000;
    end

    // Next-state, handshake, timeout and load-capture logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        off_d   = off_q;
        size_d  = size_q;
        sign_d  = sign_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        ld_d    = ld_q;
        loff_d  = loff_q;
        lsize_d = lsize_q;
        lsign_d = lsign_q;

        case (state_q)
            IDLE: begin
                if (Req) begin
                    if (req_legal_s) begin
                        state_d = ACCESS;
                        cnt_d   = 8'd0;
                        we_d    = We;
                        off_d   = Addr[1:0];
                        size_d  = Size;
                        sign_d  = Sign;
                        addr_d  = {Addr[31:2], 2'b00};
                        be_d    = req_be_s;
                        wdata_d = req_wdata_s;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                // Ack is tested first so a late ack still completes the access.
                if (MemAck) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    we_d    = 1'b0;
                    if (!we_q) begin
                        ld_d    = MemRData;
                        loff_d  = off_q;
                        lsize_d = size_q;
                        lsign_d = sign_q;
                    end else begin
                        ld_d = ld_q;
                    end
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    we_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            addr_q  <= 32'h0000_0000;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0000_0000;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ld_q    <= 32'h0000_0000;
            loff_q  <= 2'b00;
            lsize_q <= 2'b00;
            lsign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            off_q   <= off_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ld_q    <= ld_d;
            loff_q  <= loff_d;
            lsize_q <= lsize_d;
            lsign_q <= lsign_d;
        end
    end

    assign Busy     = (state_q == ACCESS);
    assign MemReq   = (state_q == ACCESS);
    assign MemWe    = we_q;
    assign MemAddr  = addr_q;
    assign MemBe    = be_q;
    assign MemWData = wdata_q;
    assign Done     = done_q;
    assign Err      = err_q;
    assign LD       = ld_q;
    assign LOff     = loff_q;
    assign LSize    = lsize_q;
    assign LSign    = lsign_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a completion scoreboard.
module tb_mem_access_ctrl;

    logic        Clk, Reset_n, Req, We, Sign, MemAck;
    logic [31:0] Addr, WData, MemRData;
    logic [1:0]  Size;
    logic        Busy, Done, Err, MemReq, MemWe, LSign;
    logic [31:0] MemAddr, MemWData, LD;
    logic [3:0]  MemBe;
    logic [1:0]  LOff, LSize;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        is_err;
        logic [31:0] ld;
        logic [1:0]  loff;
        logic [1:0]  lsize;
        logic        lsign;
    } exp_t;

    exp_t sb_q[$];

    mem_access_ctrl #(.WAIT_MAX(15)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .We(We), .Addr(Addr),
        .Size(Size), .Sign(Sign), .WData(WData), .Busy(Busy), .Done(Done),
        .Err(Err), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
        .MemBe(MemBe), .MemWData(MemWData), .MemRData(MemRData),
        .MemAck(MemAck), .LD(LD), .LOff(LOff), .LSize(LSize), .LSign(LSign)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic is_err, input logic [31:0] ld,
                           input logic [1:0] loff, input logic [1:0] lsize, input logic lsign);
        exp_t e;
        e.is_err = is_err;
        e.ld     = ld;
        e.loff   = loff;
        e.lsize  = lsize;
        e.lsign  = lsign;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_done"},  32'(Done),  32'(!e.is_err));
            chk({tag, "_err"},   32'(Err),   32'(e.is_err));
            chk({tag, "_ld"},    LD,         e.ld);
            chk({tag, "_loff"},  32'(LOff),  32'(e.loff));
            chk({tag, "_lsize"}, 32'(LSize), 32'(e.lsize));
            chk({tag, "_lsign"}, 32'(LSign), 32'(e.lsign));
        end
    endtask

    task automatic wait_result(input string tag, input int budget);
        int n = 0;
        while (!(Done || Err) && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_seen"}, 32'(Done || Err), 32'd1);
        if (Done || Err) sb_check(tag);
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic sign, input logic [31:0] wdata);
        Req = 1'b1; We = we; Addr = addr; Size = size; Sign = sign; WData = wdata;
    endtask

    initial begin
        logic [31:0] bad_addr [3];
        logic [1:0]  bad_size [3];
        int          req_cycles;

        Clk = 1'b0; Reset_n = 1'b1; Req = 1'b0; We = 1'b0; Addr = 32'h0;
        Size = 2'b00; Sign = 1'b0; WData = 32'h0; MemRData = 32'h0; MemAck = 1'b0;

        #2 Reset_n = 1'b0;
        #1;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_memreq", 32'(MemReq), 32'd0);
        chk("rst_done_err", {30'd0, Done, Err}, 32'd0);
        chk("rst_memaddr", MemAddr, 32'h0);
        chk("rst_membe", 32'(MemBe), 32'd0);
        chk("rst_ld", LD, 32'h0);
        chk("rst_lmeta", {27'd0, LOff, LSize, LSign}, 32'd0);
        tick(); tick();
        Reset_n = 1'b1;
        tick();

        // Load byte at offset 3, ack two cycles after MemReq rises.
        drive(1'b0, 32'h0000_0103, 2'b00, 1'b1, 32'hDEAD_BEEF);
        sb_push(1'b0, 32'h0000_FFFF, 2'b11, 2'b00, 1'b1);
        tick();
        Req = 1'b0; Addr = 32'hFFFF_FFFF; Size = 2'b11;
        chk("ldb_memreq", 32'(MemReq), 32'd1);
        chk("ldb_busy", 32'(Busy), 32'd1);
        chk("ldb_memaddr", MemAddr, 32'h0000_0100);
        chk("ldb_membe", 32'(MemBe), 32'b1000);
        chk("ldb_memwe", 32'(MemWe), 32'd0);
        chk("ldb_memwdata", MemWData, 32'h0);
        tick();
        chk("ldb_hold_addr", MemAddr, 32'h0000_0100);
        chk("ldb_hold_memreq", 32'(MemReq), 32'd1);
        MemRData = 32'h0000_FFFF; MemAck = 1'b1;
        tick();
        MemAck = 1'b0; MemRData = 32'h5555_5555;
        chk("ldb_done_memreq", 32'(MemReq), 32'd0);
        chk("ldb_done_busy", 32'(Busy), 32'd0);
        wait_result("ldb", 5);
        tick();
        chk("ldb_done_pulse", 32'(Done), 32'd0);

        // Store halfword at offset 2; ack held high from the request cycle.
        drive(1'b1, 32'h0000_0022, 2'b01, 1'b0, 32'h1234_ABCD);
        MemAck = 1'b1;
        sb_push(1'b0, 32'h0000_FFFF, 2'b11, 2'b00, 1'b1);
        tick();
        Req = 1'b0;
        chk("sth_memreq", 32'(MemReq), 32'd1);
        chk("sth_membe", 32'(MemBe), 32'b1100);
        chk("sth_memwdata", MemWData, 32'hABCD_ABCD);
        chk("sth_memwe", 32'(MemWe), 32'd1);
        chk("sth_memaddr", MemAddr, 32'h0000_0020);
        tick();
        MemAck = 1'b0;
        chk("sth_done_2cyc", 32'(Done), 32'd1);
        wait_result("sth", 5);
        tick();
        chk("sth_memwe_clr", 32'(MemWe), 32'd0);

        // Illegal requests: misaligned word, odd halfword, Size=11.
        bad_addr = '{32'h0000_0006, 32'h0000_0101, 32'h0000_0000};
        bad_size = '{2'b10, 2'b01, 2'b11};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, bad_addr[i], bad_size[i], 1'b0, 32'h0);
            sb_push(1'b1, 32'h0000_FFFF, 2'b11, 2'b00, 1'b1);
            tick();
            Req = 1'b0;
            chk($sformatf("ill%0d_memreq", i), 32'(MemReq), 32'd0);
            chk($sformatf("ill%0d_busy", i), 32'(Busy), 32'd0);
            wait_result($sformatf("ill%0d", i), 3);
            tick();
            chk($sformatf("ill%0d_err_pulse", i), 32'(Err), 32'd0);
            chk($sformatf("ill%0d_memreq_after", i), 32'(MemReq), 32'd0);
        end

        // No ack: MemReq high for WAIT_MAX cycles, then Err.
        drive(1'b0, 32'h0000_0040, 2'b10, 1'b0, 32'h0);
        sb_push(1'b1, 32'h0000_FFFF, 2'b11, 2'b00, 1'b1);
        tick();
        Req = 1'b0;
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (!MemReq) break;
            req_cycles++;
            tick();
        end
        chk("tmo_req_cycles", 32'(req_cycles), 32'd15);
        wait_result("tmo", 3);

        // Ack arriving in the last waiting cycle wins over timeout.
        drive(1'b0, 32'h0000_0042, 2'b01, 1'b0, 32'h0);
        sb_push(1'b0, 32'hCAFE_F00D, 2'b10, 2'b01, 1'b0);
        tick();
        Req = 1'b0;
        chk("late_membe", 32'(MemBe), 32'b1100);
        repeat (14) tick();
        chk("late_still_req", 32'(MemReq), 32'd1);
        MemAck = 1'b1; MemRData = 32'hCAFE_F00D;
        tick();
        MemAck = 1'b0;
        wait_result("late", 3);

        // Reset while MemReq is high clears everything immediately.
        drive(1'b0, 32'h0000_0080, 2'b10, 1'b1, 32'h0);
        tick();
        Req = 1'b0;
        chk("rma_memreq_pre", 32'(MemReq), 32'd1);
        Reset_n = 1'b0;
        #1;
        chk("rma_memreq", 32'(MemReq), 32'd0);
        chk("rma_busy", 32'(Busy), 32'd0);
        chk("rma_ld", LD, 32'h0);
        chk("rma_lmeta", {27'd0, LOff, LSize, LSign}, 32'd0);
        tick();
        Reset_n = 1'b1;
        tick();
        chk("rma_no_done", 32'(Done), 32'd0);
        drive(1'b0, 32'h0000_0201, 2'b00, 1'b0, 32'h0);
        sb_push(1'b0, 32'h1122_3344, 2'b01, 2'b00, 1'b0);
        tick();
        Req = 1'b0;
        chk("rma_membe", 32'(MemBe), 32'b0010);
        MemAck = 1'b1; MemRData = 32'h1122_3344;
        tick();
        MemAck = 1'b0;
        wait_result("rma_load", 3);

        // Back-to-back loads: second Req presented during the first Done cycle.
        tick();
        drive(1'b0, 32'h0000_0300, 2'b10, 1'b1, 32'h0);
        sb_push(1'b0, 32'hA5A5_A5A5, 2'b00, 2'b10, 1'b1);
        tick();
        MemAck = 1'b1; MemRData = 32'hA5A5_A5A5;
        drive(1'b0, 32'h0000_0305, 2'b00, 1'b0, 32'h0);
        sb_push(1'b0, 32'h0000_00C3, 2'b01, 2'b00, 1'b0);
        tick();
        MemAck = 1'b0;
        chk("b2b_idle_gap", 32'(MemReq), 32'd0);
        wait_result("b2b_first", 2);
        tick();
        Req = 1'b0;
        chk("b2b_memreq2", 32'(MemReq), 32'd1);
        chk("b2b_memaddr2", MemAddr, 32'h0000_0304);
        chk("b2b_membe2", 32'(MemBe), 32'b0010);
        MemAck = 1'b1; MemRData = 32'h0000_00C3;
        tick();
        MemAck = 1'b0;
        wait_result("b2b_second", 3);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
